hall_emulator: RTL and testbench

Hall-sensor signal generator for the motor drive. Produces the 3-bit Hall code on SA/SB/SC, stepping through the legal six-state sequence at a programmable step period and direction. Used as the transmit-side counterpart of the Hall sequence checker in bench and self-test builds, and as an open-loop commutation source. Optionally injects controlled sequence faults to exercise the checker's fault path.

---
 rtl/hall_pkg.sv | 42 ++++
 rtl/hall_step_timer.sv | 73 +++++++
 rtl/hall_emulator.sv | 140 ++++++++++++++
 tb/tb_hall_emulator.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hall_pkg.sv
// ---------------------------------------------------------------------------
// hall_pkg : Hall sequence table, state/injection enums and index arithmetic
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hall_pkg;

  localparam int HALL_IDX_W = 3;
  localparam logic [HALL_IDX_W:0] HALL_LEN = 6;

  // Forward order, index 0 in the low slot: 100,110,010,011,001,101
  localparam logic [5:0][2:0] HALL_SEQ = {3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

  typedef enum logic {
    IDLE,
    RUN
  } hall_state_e;

  typedef enum logic [1:0] {
    INJ_ZERO,
    INJ_ONES,
    INJ_SKIP,
    INJ_BACK
  } hall_inj_e;

  function automatic logic [2:0] hall_code(input logic [HALL_IDX_W-1:0] idx);
    return (idx > 3'd5) ? HALL_SEQ[0] : HALL_SEQ[idx];
  endfunction

  // amt is 0..5; reverse steps are passed as 6-n
  function automatic logic [HALL_IDX_W-1:0] hall_idx_add(input logic [HALL_IDX_W-1:0] idx,
                                                          input logic [HALL_IDX_W-1:0] amt);
    logic [HALL_IDX_W:0] sum;
    sum = {1'b0, idx} + {1'b0, amt};
    if (sum >= HALL_LEN) sum = sum - HALL_LEN;
    return sum[HALL_IDX_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/hall_step_timer.sv
// ---------------------------------------------------------------------------
// hall_step_timer : phase counter, step period with pending shadow, boundary
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hall_step_timer #(
  parameter int PERIOD_W = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_run,
  input  logic                i_idle,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_load,
  output logic                o_boundary,
  output logic                o_period_ok,
  output logic                o_stop_commit,
  output logic                o_period_ack
);

  localparam logic [PERIOD_W-1:0] c_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

  logic [PERIOD_W-1:0] r_phase;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_pend_period;
  logic                r_pend_valid;
  logic                r_ack;

  logic w_boundary;
  logic w_commit;

  assign w_boundary    = i_run && (r_phase == (r_period - c_ONE));
  assign w_commit      = w_boundary && r_pend_valid;
  assign o_boundary    = w_boundary;
  assign o_period_ok   = |r_period[PERIOD_W-1:1];
  assign o_stop_commit = w_commit && (r_pend_period[PERIOD_W-1:1] == '0);
  assign o_period_ack  = r_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase       <= '0;
      r_period      <= '0;
      r_pend_period <= '0;
      r_pend_valid  <= 1'b0;
      r_ack         <= 1'b0;
    end else begin
      r_ack <= 1'b0;

      if (!i_run || w_boundary) r_phase <= '0;
      else                      r_phase <= r_phase + c_ONE;

      if (i_idle && i_load) begin
        r_period <= i_period;
        r_ack    <= 1'b1;
      end else begin
        if (w_commit) begin
          r_period     <= r_pend_period;
          r_pend_valid <= 1'b0;
          r_ack        <= 1'b1;
        end
        // A load coinciding with a commit is held for the following boundary
        if (i_load) begin
          r_pend_period <= i_period;
          r_pend_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hall_emulator.sv
// ---------------------------------------------------------------------------
// hall_emulator : six-state Hall code generator; fault injection when
// HALL_FAULT_INJECT_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hall_emulator
  import hall_pkg::*;
#(
  parameter int PERIOD_W   = 17,
  parameter int STEP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  dir,
  input  logic [PERIOD_W-1:0]   period_in,
  input  logic                  period_load,
  output logic                  period_ack,
  output logic                  SA_out,
  output logic                  SB_out,
  output logic                  SC_out,
  output logic                  step_pulse,
  output logic [STEP_CNT_W-1:0] step_count,
  output logic                  busy
`ifdef HALL_FAULT_INJECT_EN
  ,
  input  logic                  inj_req,
  input  logic [1:0]            inj_mode,
  output logic                  inj_ack
`endif
);

  localparam logic [STEP_CNT_W-1:0] c_CNT_ONE = {{(STEP_CNT_W-1){1'b0}}, 1'b1};

  hall_state_e               r_state;
  logic [HALL_IDX_W-1:0]     r_idx;
  logic [2:0]                r_code;
  logic                      r_step_pulse;
  logic [STEP_CNT_W-1:0]     r_step_count;

  logic                      w_step;
  logic                      w_period_ok;
  logic                      w_stop;
  logic [HALL_IDX_W-1:0]     w_amt;
  logic [HALL_IDX_W-1:0]     w_next_idx;
  logic [2:0]                w_next_code;
  logic                      w_force;
  logic [2:0]                w_force_code;

`ifdef HALL_FAULT_INJECT_EN
  logic                      r_inj_pend;
  hall_inj_e                 r_inj_mode;
  logic                      r_inj_ack;
`endif

  hall_step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk           (clk),
    .rst_n         (reset),
    .i_run         ((r_state == RUN) && enable),
    .i_idle        (r_state == IDLE),
    .i_period      (period_in),
    .i_load        (period_load),
    .o_boundary    (w_step),
    .o_period_ok   (w_period_ok),
    .o_stop_commit (w_stop),
    .o_period_ack  (period_ack)
  );

  // Forced fault codes leave the index untouched so the next step resumes legally
  always_comb begin
    w_amt        = dir ? 3'd1 : 3'd5;
    w_force      = 1'b0;
    w_force_code = 3'b000;
`ifdef HALL_FAULT_INJECT_EN
    if (r_inj_pend) begin
      case (r_inj_mode)
        INJ_ZERO: begin w_amt = 3'd0; w_force = 1'b1; w_force_code = 3'b000; end
        INJ_ONES: begin w_amt = 3'd0; w_force = 1'b1; w_force_code = 3'b111; end
        INJ_SKIP: w_amt = dir ? 3'd2 : 3'd4;
        INJ_BACK: w_amt = dir ? 3'd5 : 3'd1;
        default:  w_amt = dir ? 3'd1 : 3'd5;
      endcase
    end
`endif
    w_next_idx  = hall_idx_add(r_idx, w_amt);
    w_next_code = w_force ? w_force_code : hall_code(w_next_idx);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_code       <= 3'b100;
      r_step_pulse <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_step_pulse <= w_step;
      case (r_state)
        IDLE:    if (enable && w_period_ok) r_state <= RUN;
        RUN:     if (!enable || w_stop) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_step) begin
        r_idx        <= w_next_idx;
        r_code       <= w_next_code;
        r_step_count <= r_step_count + c_CNT_ONE;
      end
    end
  end

`ifdef HALL_FAULT_INJECT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inj_pend <= 1'b0;
      r_inj_mode <= INJ_ZERO;
      r_inj_ack  <= 1'b0;
    end else begin
      r_inj_ack <= w_step && r_inj_pend;
      if (w_step) r_inj_pend <= 1'b0;
      if (inj_req) begin
        r_inj_pend <= 1'b1;
        r_inj_mode <= hall_inj_e'(inj_mode);
      end
    end
  end

  assign inj_ack = r_inj_ack;
`endif

  assign {SA_out, SB_out, SC_out} = r_code;
  assign step_pulse = r_step_pulse;
  assign step_count = r_step_count;
  assign busy       = (r_state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_hall_emulator.sv
// ---------------------------------------------------------------------------
// tb_hall_emulator : randomized and directed checks against a reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hall_emulator;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        dir;
  logic [16:0] period_in;
  logic        period_load;
  logic        period_ack;
  logic        SA_out, SB_out, SC_out;
  logic        step_pulse;
  logic [15:0] step_count;
  logic        busy;
`ifdef HALL_FAULT_INJECT_EN
  logic        inj_req;
  logic [1:0]  inj_mode;
  logic        inj_ack;
`endif

  hall_emulator #(
    .PERIOD_W   (17),
    .STEP_CNT_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .dir         (dir),
    .period_in   (period_in),
    .period_load (period_load),
    .period_ack  (period_ack),
    .SA_out      (SA_out),
    .SB_out      (SB_out),
    .SC_out      (SC_out),
    .step_pulse  (step_pulse),
    .step_count  (step_count),
    .busy        (busy)
`ifdef HALL_FAULT_INJECT_EN
    ,
    .inj_req     (inj_req),
    .inj_mode    (inj_mode),
    .inj_ack     (inj_ack)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [2:0] SEQ [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

  // Reference model state
  bit         m_run;
  int         m_period, m_pend, m_elapsed, m_idx, m_count;
  bit         m_pend_v, m_pulse, m_ack, m_inj_ack, m_inj_pend;
  int         m_inj_mode;
  logic [2:0] m_code;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_period = 0; m_pend = 0; m_pend_v = 0; m_elapsed = 0;
    m_idx = 0; m_code = SEQ[0]; m_pulse = 0; m_ack = 0; m_count = 0;
    m_inj_ack = 0; m_inj_pend = 0; m_inj_mode = 0;
  endtask

  task automatic model_step();
    int   nxt;
    bit   forced;
    logic [2:0] fc;
    forced = 0;
    fc     = 3'b000;
    nxt    = dir ? (m_idx + 1) % 6 : (m_idx + 5) % 6;
    if (m_inj_pend) begin
      m_inj_ack  = 1;
      m_inj_pend = 0;
      case (m_inj_mode)
        0: begin nxt = m_idx; forced = 1; fc = 3'b000; end
        1: begin nxt = m_idx; forced = 1; fc = 3'b111; end
        2: nxt = dir ? (m_idx + 2) % 6 : (m_idx + 4) % 6;
        default: nxt = dir ? (m_idx + 5) % 6 : (m_idx + 1) % 6;
      endcase
    end
    m_idx   = nxt;
    m_code  = forced ? fc : SEQ[nxt];
    m_pulse = 1;
    m_count = (m_count + 1) % 65536;
  endtask

  // Advances the model by one clock using the inputs sampled at this edge
  task automatic model_update();
    bit go;
    if (!reset) begin
      model_reset();
      return;
    end
    m_pulse = 0; m_ack = 0; m_inj_ack = 0;
    if (!m_run) begin
      go = enable && (m_period >= 2);
      if (period_load) begin m_period = int'(period_in); m_ack = 1; end
      if (go) begin m_run = 1; m_elapsed = 0; end
    end else if (!enable) begin
      m_run = 0; m_elapsed = 0;
      if (period_load) begin m_pend = int'(period_in); m_pend_v = 1; end
    end else begin
      m_elapsed++;
      if (m_elapsed == m_period) begin
        m_elapsed = 0;
        model_step();
        if (m_pend_v) begin
          m_period = m_pend; m_pend_v = 0; m_ack = 1;
          if (m_period < 2) m_run = 0;
        end
      end
      if (period_load) begin m_pend = int'(period_in); m_pend_v = 1; end
    end
`ifdef HALL_FAULT_INJECT_EN
    if (inj_req) begin m_inj_pend = 1; m_inj_mode = int'(inj_mode); end
`endif
  endtask

  task automatic compare_model();
    check_eq("code",  {SA_out, SB_out, SC_out}, m_code);
    check_eq("pulse", step_pulse, m_pulse);
    check_eq("ack",   period_ack, m_ack);
    check_eq("count", step_count, m_count);
    check_eq("busy",  busy, m_run);
`ifdef HALL_FAULT_INJECT_EN
    check_eq("inj_ack", inj_ack, m_inj_ack);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_model();
  endtask

  task automatic async_reset_check();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("rst_async_code",  {SA_out, SB_out, SC_out}, 3'b100);
    check_eq("rst_async_count", step_count, 0);
    check_eq("rst_async_busy",  busy, 0);
    check_eq("rst_async_pulse", step_pulse, 0);
  endtask

  logic [2:0] fwd_exp [6] = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100};

  initial begin
    reset = 1'b0; enable = 1'b0; dir = 1'b1; period_in = '0; period_load = 1'b0;
`ifdef HALL_FAULT_INJECT_EN
    inj_req = 1'b0; inj_mode = 2'd0;
`endif
    model_reset();
    repeat (2) tick();
    check_eq("rst_code", {SA_out, SB_out, SC_out}, 3'b100);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_count", step_count, 0);
    reset = 1'b1;

    // Forward walk at period 4
    period_in = 17'd4; period_load = 1'b1; tick();
    check_eq("ack_idle_load", period_ack, 1);
    period_load = 1'b0; enable = 1'b1; dir = 1'b1; tick();
    check_eq("busy_start", busy, 1);
    for (int s = 0; s < 6; s++) begin
      repeat (3) tick();
      check_eq("fwd_no_pulse", step_pulse, 0);
      tick();
      check_eq("fwd_code", {SA_out, SB_out, SC_out}, fwd_exp[s]);
      check_eq("fwd_pulse", step_pulse, 1);
    end
    check_eq("fwd_count6", step_count, 6);

    // Reverse walk at period 3, index wraps 0 -> 5
    enable = 1'b0; tick();
    check_eq("busy_stop", busy, 0);
    period_in = 17'd3; period_load = 1'b1; tick();
    period_load = 1'b0; dir = 1'b0; enable = 1'b1; tick();
    repeat (3) tick();
    check_eq("rev_code1", {SA_out, SB_out, SC_out}, 3'b101);
    repeat (3) tick();
    check_eq("rev_code2", {SA_out, SB_out, SC_out}, 3'b001);

    // Period reload while running
    enable = 1'b0; tick();
    period_in = 17'd5; period_load = 1'b1; tick();
    period_load = 1'b0; dir = 1'b1; enable = 1'b1; tick();
    repeat (2) tick();
    period_in = 17'd10; period_load = 1'b1; tick();
    period_load = 1'b0; repeat (2) tick();
    check_eq("reload_pulse", step_pulse, 1);
    check_eq("reload_ack", period_ack, 1);
    repeat (9) tick();
    check_eq("p10_no_pulse", step_pulse, 0);
    tick();
    check_eq("p10_pulse", step_pulse, 1);
    check_eq("p10_no_ack", period_ack, 0);
    period_in = 17'd7; period_load = 1'b1; tick();
    period_in = 17'd9; tick();
    period_load = 1'b0; repeat (8) tick();
    check_eq("lastwin_pulse", step_pulse, 1);
    check_eq("lastwin_ack", period_ack, 1);
    repeat (8) tick();
    check_eq("p9_no_pulse", step_pulse, 0);
    tick();
    check_eq("p9_pulse", step_pulse, 1);

    // enable drops in the boundary cycle
    repeat (8) tick();
    enable = 1'b0; tick();
    check_eq("drop_no_pulse", step_pulse, 0);
    check_eq("drop_busy", busy, 0);
    period_in = 17'd1; period_load = 1'b1; tick();
    check_eq("p1_ack", period_ack, 1);
    period_load = 1'b0; enable = 1'b1; repeat (5) tick();
    check_eq("p1_stays_idle", busy, 0);

`ifdef HALL_FAULT_INJECT_EN
    enable = 1'b0; reset = 1'b0; tick(); reset = 1'b1;
    period_in = 17'd4; period_load = 1'b1; tick();
    period_load = 1'b0; inj_req = 1'b1; inj_mode = 2'd2; tick();
    inj_req = 1'b0; dir = 1'b1; enable = 1'b1; tick();
    repeat (4) tick();
    check_eq("skip_code", {SA_out, SB_out, SC_out}, 3'b010);
    check_eq("skip_ack", inj_ack, 1);
    inj_req = 1'b1; inj_mode = 2'd1; tick();
    check_eq("skip_ack_once", inj_ack, 0);
    inj_req = 1'b0; repeat (3) tick();
    check_eq("ones_ack", inj_ack, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq("ones_code", {SA_out, SB_out, SC_out}, 3'b111);
      tick();
    end
    check_eq("ones_resume", {SA_out, SB_out, SC_out}, 3'b011);
`endif

    // Reset mid-RUN
    enable = 1'b0; period_in = 17'd3; period_load = 1'b1; tick();
    period_load = 1'b0; enable = 1'b1; repeat (7) tick();
    check_eq("pre_rst_busy", busy, 1);
    async_reset_check();
    tick();
    reset = 1'b1;

    // Randomized traffic against the model
    for (int it = 0; it < 3000; it++) begin
      reset = 1'b1;
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      if (!m_run && $urandom_range(0, 99) < 8) enable = 1'b1;
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      period_load = ($urandom_range(0, 24) == 0);
      period_in = ($urandom_range(0, 9) == 0) ? 17'($urandom_range(0, 1)) : 17'($urandom_range(2, 7));
      if (period_load && !m_run) enable = 1'b0;
`ifdef HALL_FAULT_INJECT_EN
      inj_req  = ($urandom_range(0, 29) == 0);
      inj_mode = 2'($urandom_range(0, 3));
`endif
      if ($urandom_range(0, 499) == 0) async_reset_check();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
